// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, input clamp limit and
// active-low glyph codes in {dp,g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int          DIG_NUM  = 6;
  localparam logic [19:0] DATA_MAX = 20'd999_999;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Map one BCD digit to its glyph with the decimal point off.
  function automatic logic [7:0] digit_glyph(input bcd_t d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_8421.sv
// Binary to six-digit 8421 BCD converter. Shift-and-add-3 is unrolled
// combinationally and the result is registered, giving one cycle latency.
module bcd_8421
  import seg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  output bcd_t        unit,
  output bcd_t        ten,
  output bcd_t        hun,
  output bcd_t        tho,
  output bcd_t        t_tho,
  output bcd_t        h_hun
);

  logic [23:0] bcd_d;
  logic [23:0] bcd_q;

  // Double-dabble: before each shift, bump any digit above 4 by 3.
  always_comb begin
    bcd_d = '0;
    for (int i = 19; i >= 0; i--) begin
      for (int d = 0; d < 6; d++) begin
        if (bcd_d[4*d +: 4] > 4'd4) begin
          bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
        end
      end
      bcd_d = {bcd_d[22:0], data[i]};
    end
  end

  // Output register for the converted digits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign unit  = bcd_q[3:0];
  assign ten   = bcd_q[7:4];
  assign hun   = bcd_q[11:8];
  assign tho   = bcd_q[15:12];
  assign t_tho = bcd_q[19:16];
  assign h_hun = bcd_q[23:20];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller. Each digit is driven
// for CNT_MAX+1 cycles; a complete frame of digits, points and sign is
// latched once per scan so a frame is never torn by input changes.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  logic [19:0]                data_clamp;
  bcd_t                       unit, ten, hun, tho, t_tho, h_hun;
  logic [DIG_NUM-1:0][3:0]    dig_live;

  logic [15:0]                cnt_d, cnt_q;
  logic [2:0]                 idx_d, idx_q;
  logic                       wrap;
  logic                       frame_end;

  logic [DIG_NUM-1:0][3:0]    dig_d, dig_q;
  logic [DIG_NUM-1:0]         point_d, point_q;
  logic                       sign_d, sign_q;

  logic [DIG_NUM-1:0]         blank;
  logic [DIG_NUM-1:0]         minus;
  logic                       lit_above;
  logic [7:0]                 glyph;

  logic [5:0]                 sel_d, sel_q;
  logic [7:0]                 seg_d, seg_q;

  // Saturate anything beyond six decimal digits.
  always_comb begin
    data_clamp = (data > DATA_MAX) ? DATA_MAX : data;
  end

  bcd_8421 u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data_clamp),
    .unit      (unit),
    .ten       (ten),
    .hun       (hun),
    .tho       (tho),
    .t_tho     (t_tho),
    .h_hun     (h_hun)
  );

  assign dig_live = {h_hun, t_tho, tho, hun, ten, unit};

  // Dwell counter and digit index; disabling parks both at zero.
  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    frame_end = seg_en && wrap && (idx_q == 3'(DIG_NUM - 1));
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (!seg_en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(DIG_NUM - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Frame latch: capture converted digits, points and sign on the last-digit wrap.
  always_comb begin
    dig_d   = dig_q;
    point_d = point_q;
    sign_d  = sign_q;
    if (frame_end) begin
      dig_d   = dig_live;
      point_d = point;
      sign_d  = sign;
    end
  end

  // Leading-zero blanking from the top digit down; minus goes in the lowest blank.
  always_comb begin
    blank     = '0;
    minus     = '0;
    lit_above = 1'b0;
    for (int i = DIG_NUM - 1; i >= 1; i--) begin
      lit_above = lit_above | (dig_q[i] != 4'd0) | point_q[i];
      blank[i]  = ~lit_above;
    end
    for (int i = 1; i < DIG_NUM; i++) begin
      minus[i] = sign_q & blank[i] & ~blank[i-1];
    end
  end

  // Glyph for the digit under scan and the next select/segment values.
  always_comb begin
    glyph = SEG_BLANK;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (idx_q == 3'(i)) begin
        if (blank[i]) begin
          glyph = minus[i] ? SEG_MINUS : SEG_BLANK;
        end else begin
          glyph = digit_glyph(dig_q[i]);
          if (point_q[i]) begin
            glyph[7] = 1'b0;
          end
        end
      end
    end
    sel_d = '0;
    seg_d = SEG_BLANK;
    if (seg_en) begin
      sel_d = 6'b1 << idx_q;
      seg_d = glyph;
    end
  end

  // State, frame and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      point_q <= '0;
      sign_q  <= 1'b0;
      sel_q   <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      point_q <= point_d;
      sign_q  <= sign_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 10-cycle dwell (60-cycle frame).
module tb_seg_scan_ctrl;

  typedef logic [5:0][7:0] frame_t;

  typedef struct {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    frame_t      exp;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  vec_t   vecs[9];
  frame_t rst_frame;

  seg_scan_ctrl #(.CNT_MAX(16'd9)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg)
  );

  initial forever #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic frame_t mk(input logic [7:0] g0, g1, g2, g3, g4, g5);
    return {g5, g4, g3, g2, g1, g0};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples cycles [first,last) of a frame on negedges; one comparison per digit touched.
  task automatic run_frame(input frame_t exp, input int first, input int last, input string tag);
    logic       bad[6];
    logic [5:0] asel[6];
    logic [7:0] aseg[6];
    logic [5:0] esel;
    int         d;
    for (int k = 0; k < 6; k++) begin
      bad[k]  = 1'b0;
      asel[k] = '0;
      aseg[k] = '0;
    end
    for (int c = first; c < last; c++) begin
      @(negedge sys_clk);
      d    = c / 10;
      esel = 6'(1 << d);
      if ((sel !== esel || seg !== exp[d]) && !bad[d]) begin
        bad[d]  = 1'b1;
        asel[d] = sel;
        aseg[d] = seg;
      end
    end
    for (int k = first / 10; k <= (last - 1) / 10; k++) begin
      checks++;
      if (bad[k]) begin
        failures++;
        $display("FAIL %s digit %0d: got sel=%b seg=%h expected sel=%b seg=%h",
                 tag, k, asel[k], aseg[k], 6'(1 << k), exp[k]);
      end
    end
  endtask

  initial begin
    frame_t e8;
    frame_t e654321;
    frame_t e42;

    sys_rst_n = 1'b0;
    data      = '0;
    point     = '0;
    sign      = 1'b0;
    seg_en    = 1'b1;

    rst_frame = mk(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[0] = '{20'd123456,  6'b000000, 1'b0, mk(8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9)};
    vecs[1] = '{20'd42,      6'b000000, 1'b1, mk(8'hA4, 8'h99, 8'hBF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[2] = '{20'd5,       6'b000100, 1'b0, mk(8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF)};
    vecs[3] = '{20'd1048575, 6'b000000, 1'b0, mk(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    vecs[4] = '{20'd0,       6'b000000, 1'b1, mk(8'hC0, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[5] = '{20'd999999,  6'b000000, 1'b1, mk(8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90)};
    vecs[6] = '{20'd100,     6'b100000, 1'b0, mk(8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'h40)};
    vecs[7] = '{20'd7,       6'b000001, 1'b1, mk(8'h78, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[8] = '{20'd120,     6'b000000, 1'b0, mk(8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF)};
    e8      = vecs[8].exp;
    e654321 = mk(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82);
    e42     = mk(8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset state with the clock running
    repeat (3) @(negedge sys_clk);
    check("reset_sel", {2'b00, sel}, 8'h00);
    check("reset_seg", seg, 8'hFF);

    sys_rst_n = 1'b1;

    // Each frame shows what was applied during the frame before it
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        data  = vecs[i].data;
        point = vecs[i].point;
        sign  = vecs[i].sign;
      end
      if (i == 0) run_frame(rst_frame, 0, 60, "reset_frame");
      else        run_frame(vecs[i-1].exp, 0, 60, $sformatf("vec%0d", i - 1));
    end

    // Disable while digit 3 is scanned, then re-enable
    repeat (33) @(negedge sys_clk);
    check("pre_disable_sel", {2'b00, sel}, 8'h08);
    seg_en = 1'b0;
    @(negedge sys_clk);
    check("disable_sel", {2'b00, sel}, 8'h00);
    check("disable_seg", seg, 8'hFF);
    repeat (5) @(negedge sys_clk);
    check("disabled_hold_sel", {2'b00, sel}, 8'h00);
    check("disabled_hold_seg", seg, 8'hFF);
    seg_en = 1'b1;
    @(negedge sys_clk);
    check("reenable_sel", {2'b00, sel}, 8'h01);
    check("reenable_seg", seg, 8'hC0);

    // Mid-frame data change must not disturb the current frame
    run_frame(e8, 1, 25, "restart_frame_a");
    data  = 20'd654321;
    point = '0;
    sign  = 1'b0;
    run_frame(e8, 25, 60, "restart_frame_b");
    run_frame(e654321, 0, 60, "after_midframe_change");

    // Asynchronous reset in the middle of a frame
    repeat (27) @(negedge sys_clk);
    check("pre_reset_sel", {2'b00, sel}, 8'h04);
    check("pre_reset_seg", seg, 8'hB0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset_sel", {2'b00, sel}, 8'h00);
    check("async_reset_seg", seg, 8'hFF);
    data = 20'd42;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_frame(rst_frame, 0, 60, "post_reset_frame");
    run_frame(e42, 0, 60, "post_reset_live");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CNT_MAX, default 16'd49_999: last value of the per-digit dwell counter (1 ms at 50 MHz).
REQ-002 SHALL have port sys_clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port data, input, 20: unsigned binary value to display.
REQ-005 SHALL have port point, input, 6: decimal-point enables; bit i lights the dp of digit i.
REQ-006 SHALL have port sign, input, 1: 1 = show a minus sign.
REQ-007 SHALL have port seg_en, input, 1: 1 = scanning enabled.
REQ-008 SHALL have port sel, output, 6: one-hot active-high digit select; bit 0 = units digit.
REQ-009 SHALL have port seg, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-010 SHALL clamp data to 999_999 when data > 999_999, before BCD conversion.
REQ-011 SHALL run dwell counter cnt 0..CNT_MAX, wrapping to 0, while seg_en=1.
REQ-012 SHALL advance digit index idx 0->1->...->5->0 in the cycle cnt wraps.
REQ-013 SHALL register sel and seg: both reflect idx one cycle after idx changes.
REQ-014 SHALL latch six BCD digits, point and sign into frame registers at the cnt wrap where idx goes 5->0; mid-frame input changes SHALL NOT affect the current frame.
REQ-015 SHALL use glyphs (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, minus=BF.
REQ-016 SHALL clear seg[7] to 0 for digit i when latched point[i]=1 and digit i is not blank.
REQ-017 SHALL blank digit i (i>0) when all latched digits j>=i are zero and no latched point[k] with k>=i is set; digit 0 is never blanked.
REQ-018 SHALL show minus in the lowest blanked digit when latched sign=1; if no digit is blanked, sign SHALL be ignored.
REQ-019 SHALL force sel=0, seg=FF and hold cnt=0, idx=0 on the cycle after seg_en falls.
REQ-020 SHALL restart at idx=0 with sel=000001 one cycle after seg_en rises; frame registers SHALL be retained while seg_en=0.

Reset
REQ-021 SHALL set sel=6'b0, seg=8'hFF, cnt=0, idx=0 and all frame registers to 0 while sys_rst_n=0, independent of sys_clk.
REQ-022 SHALL display the reset frame (single "0" at digit 0) during the first frame after reset release; live data SHALL appear from the second frame.
REQ-023 SHALL abandon a frame in progress on reset assertion, with no partial latch.

Structure
REQ-024 SHALL take glyph constants (digit codes, BLANK, MINUS) and the DIG_NUM=6 constant from the shared seg package.
REQ-025 SHALL instantiate the existing bcd_8421 as its only sub-module for conversion (sys_clk, sys_rst_n, clamped data -> unit..h_hun); its conversion latency is < CNT_MAX+1 cycles, so a value stable for one frame is fully converted at the next latch.
REQ-026 SHALL keep the scan counter, index, frame latch and glyph/blank/sign decode in seg_scan_ctrl itself.

Verification (CNT_MAX=9: 10 cycles/digit, 60 cycles/frame)
REQ-027 SHALL check: data=123_456, point=0, sign=0 -> second frame seg per digit 0..5 = 82,92,99,B0,A4,F9, each for 10 cycles, sel 000001..100000.
REQ-028 SHALL check: data=42, sign=1 -> digits 0..5 = A4,99,BF,FF,FF,FF.
REQ-029 SHALL check: data=5, point=000100 -> digits 0..5 = 92,C0,40,FF,FF,FF.
REQ-030 SHALL check: data=1_048_575 -> all six digits = 90.
REQ-031 SHALL check: seg_en low at idx=3 -> next cycle sel=0, seg=FF; seg_en high -> next cycle sel=000001; data changed mid-frame -> old glyphs until the next 5->0 wrap.
REQ-032 SHALL check: sys_rst_n low mid-frame -> sel=0, seg=FF immediately; after release, first frame shows C0 on digit 0 and FF on digits 1..5.
